// File: rtl/apb_pkg.sv
// Shared state encoding and sizing helpers for the APB register-file completer.
// No timing of its own; used by apb_slave_regfile and apb_slave_regbank.
package apb_pkg;
  localparam int APB_DEF_WIDTH    = 16;
  localparam int APB_DEF_NUM_REGS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  // Bits needed to index n entries, kept at 1 or more so a one-entry bank still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int APB_DEF_IDX_W = idx_w(APB_DEF_NUM_REGS);
endpackage

// File: rtl/apb_slave_regbank.sv
// Register array: one synchronous write port, one combinational read port (0 when out of range).
// Write lands on the clock edge where we is high; there is no backpressure and the bank is always ready.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int WIDTH    = APB_DEF_WIDTH,
  parameter int NUM_REGS = APB_DEF_NUM_REGS,
  parameter int IW       = idx_w(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam logic [IW:0] NR = (IW + 1)'(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             waddr_ok;
  logic             raddr_ok;

  // Only matters when NUM_REGS is not a power of two and the index can exceed the array.
  assign waddr_ok = ({1'b0, waddr} < NR);
  assign raddr_ok = ({1'b0, raddr} < NR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = raddr_ok ? regs[raddr] : '0;
endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer over a register bank; pready/prdata/pslverr registered, pslverr enabled by APB_SLVERR_EN.
// Latency: setup cycle, then WAIT_CYCLES wait states, then a single pready cycle; a master abort returns to IDLE.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int WIDTH       = APB_DEF_WIDTH,
  parameter int NUM_REGS    = APB_DEF_NUM_REGS,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             pselect,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  output logic             pslverr
);
  localparam int             IW       = idx_w(NUM_REGS);
  localparam int             CW       = idx_w(WAIT_CYCLES + 1);
  localparam logic [WIDTH:0] NR       = (WIDTH + 1)'(NUM_REGS);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic             lat_write;

  logic             take_setup;
  logic             enter_ready;
  logic             commit;
  logic [WIDTH-1:0] cur_addr;
  logic             cur_write;
  logic             cur_ok;
  logic [WIDTH-1:0] bank_rdata;
  logic [WIDTH-1:0] rdata_nxt;
  logic             err_nxt;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pselect && !penable) begin
          state_nxt = (WAIT_CYCLES == 0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!pselect) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_ONE) begin
          state_nxt = READY;
        end
      end
      READY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In the setup cycle the latches are not loaded yet, so a zero-wait read must look at the live bus.
  always_comb begin
    take_setup  = (state == IDLE) && pselect && !penable;
    cur_addr    = take_setup ? paddr  : lat_addr;
    cur_write   = take_setup ? pwrite : lat_write;
    cur_ok      = ({1'b0, cur_addr} < NR);
    enter_ready = (state_nxt == READY);
    commit      = (state == READY) && pselect && lat_write && cur_ok;
    rdata_nxt   = (enter_ready && !cur_write && cur_ok) ? bank_rdata : '0;
`ifdef APB_SLVERR_EN
    err_nxt     = enter_ready && !cur_ok;
`else
    err_nxt     = 1'b0;
`endif
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
    end else begin
      if (take_setup) begin
        lat_addr  <= paddr;
        lat_write <= pwrite;
        lat_wdata <= pwdata;
        cnt       <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_ONE;
      end
      pready  <= enter_ready;
      prdata  <= rdata_nxt;
      pslverr <= err_nxt;
    end
  end

  apb_slave_regbank #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_bank (
    .clk   (pclk),
    .rst   (preset),
    .we    (commit && !preset),
    .waddr (lat_addr[IW-1:0]),
    .wdata (lat_wdata),
    .raddr (cur_addr[IW-1:0]),
    .rdata (bank_rdata)
  );
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (1, 0 and 3 wait states) against a register model and scoreboard.
module tb_apb_slave_regfile;
  localparam int W = 16;

`ifdef APB_SLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] rd;
    logic         err;
    int           lat;
  } exp_t;

  typedef struct {
    logic         wr;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [3];
  logic         psel [3];
  logic         pen  [3];
  logic         pwr  [3];
  logic [W-1:0] padr [3];
  logic [W-1:0] pwd  [3];
  logic         prdy [3];
  logic [W-1:0] prd  [3];
  logic         perr [3];

  logic [W-1:0] model [3][16];
  exp_t         sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;

  apb_slave_regfile #(.WIDTH(W), .NUM_REGS(16), .WAIT_CYCLES(1)) u0 (
    .pclk(clk), .preset(rst[0]), .pselect(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(padr[0]), .pwdata(pwd[0]), .pready(prdy[0]), .prdata(prd[0]), .pslverr(perr[0]));
  apb_slave_regfile #(.WIDTH(W), .NUM_REGS(16), .WAIT_CYCLES(0)) u1 (
    .pclk(clk), .preset(rst[1]), .pselect(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(padr[1]), .pwdata(pwd[1]), .pready(prdy[1]), .prdata(prd[1]), .pslverr(perr[1]));
  apb_slave_regfile #(.WIDTH(W), .NUM_REGS(16), .WAIT_CYCLES(3)) u2 (
    .pclk(clk), .preset(rst[2]), .pselect(psel[2]), .penable(pen[2]), .pwrite(pwr[2]),
    .paddr(padr[2]), .pwdata(pwd[2]), .pready(prdy[2]), .prdata(prd[2]), .pslverr(perr[2]));

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // Expected completion of one transfer, from the register model.
  function automatic void push_exp(input int d, input logic wr, input logic [W-1:0] a, input logic [W-1:0] dat);
    exp_t e;
    e.lat = wc(d) + 1;
    e.err = (a >= 16) ? ERR_EXP : 1'b0;
    e.rd  = (!wr && a < 16) ? model[d][a[3:0]] : '0;
    if (wr && a < 16) model[d][a[3:0]] = dat;
    sb.push_back(e);
  endfunction

  // Runs one transfer; stray counts cycles where pready/prdata/pslverr were non-zero outside the completion.
  task automatic do_xfer(input int d, input logic wr, input logic [W-1:0] a, input logic [W-1:0] dat,
                         output int lat, output logic [W-1:0] rd, output logic err, output int stray);
    stray = 0;
    lat   = -1;
    rd    = '0;
    err   = 1'b0;
    @(posedge clk); #1;
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; padr[d] = a; pwd[d] = dat;
    @(negedge clk);
    if (prdy[d] !== 1'b0 || prd[d] !== '0 || perr[d] !== 1'b0) stray++;
    @(posedge clk); #1;
    pen[d] = 1'b1; padr[d] = a ^ 16'h0001; pwd[d] = ~dat;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (prdy[d] === 1'b1) begin
        lat = k; rd = prd[d]; err = perr[d];
        break;
      end
      if (prdy[d] !== 1'b0 || prd[d] !== '0 || perr[d] !== 1'b0) stray++;
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle(input int d, output int stray);
    @(posedge clk); #1;
    psel[d] = 1'b0; pen[d] = 1'b0;
    @(negedge clk);
    stray = (prdy[d] !== 1'b0 || prd[d] !== '0 || perr[d] !== 1'b0) ? 1 : 0;
  endtask

  task automatic test_reset();
    int lat, stray, bad;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (prdy[d] !== 1'b0 || prd[d] !== '0 || perr[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: pready=%b prdata=%h pslverr=%b, want 0/0000/0", d, prdy[d], prd[d], perr[d]);
      end
    end
    push_exp(0, 1'b1, 16'd3, 16'h5555);
    do_xfer(0, 1'b1, 16'd3, 16'h5555, lat, rd, err, stray);
    e = sb.pop_front();
    n_cmp++;
    if (lat != e.lat || stray != 0) begin
      n_bad++;
      $display("FAIL reset_prewrite: latency %0d stray %0d, want %0d / 0", lat, stray, e.lat);
    end
    // Start a write and hit it with a two-cycle reset while it is waiting.
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; padr[0] = 16'd3; pwd[0] = 16'h7777;
    @(posedge clk); #1;
    pen[0] = 1'b1; rst[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (prdy[0] !== 1'b0 || prd[0] !== '0 || perr[0] !== 1'b0) bad++;
      @(posedge clk); #1;
      if (k == 1) begin
        rst[0] = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_midxfer: %0d cycles with non-zero outputs, want 0", bad);
    end
    for (int a = 0; a < 16; a++) model[0][a] = '0;
    push_exp(0, 1'b0, 16'd3, 16'h0000);
    do_xfer(0, 1'b0, 16'd3, 16'h0000, lat, rd, err, stray);
    e = sb.pop_front();
    n_cmp++;
    if (rd !== e.rd || lat != e.lat) begin
      n_bad++;
      $display("FAIL reset_readback: prdata %h latency %0d, want %h / %0d", rd, lat, e.rd, e.lat);
    end
    go_idle(0, stray);
  endtask

  task automatic test_write_read();
    op_t ops[$];
    int lat, stray;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    ops.push_back('{wr: 1'b1, a: 16'd2, d: 16'hA5A5});
    ops.push_back('{wr: 1'b0, a: 16'd2, d: 16'h0000});
    ops.push_back('{wr: 1'b1, a: 16'd9, d: 16'h3C3C});
    ops.push_back('{wr: 1'b0, a: 16'd9, d: 16'h0000});
    foreach (ops[i]) begin
      push_exp(0, ops[i].wr, ops[i].a, ops[i].d);
      do_xfer(0, ops[i].wr, ops[i].a, ops[i].d, lat, rd, err, stray);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL wr_rd[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (rd !== e.rd) begin n_bad++; $display("FAIL wr_rd[%0d] prdata: got %h want %h", i, rd, e.rd); end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL wr_rd[%0d] idle outputs: %0d stray cycles, want 0", i, stray); end
    end
    go_idle(0, stray);
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL wr_rd pready after last: stray %0d want 0", stray); end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    int lat, stray;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    ops.push_back('{wr: 1'b1, a: 16'd0, d: 16'h1234});
    ops.push_back('{wr: 1'b0, a: 16'd0, d: 16'h0000});
    ops.push_back('{wr: 1'b1, a: 16'd7, d: 16'h00FF});
    ops.push_back('{wr: 1'b0, a: 16'd7, d: 16'h0000});
    ops.push_back('{wr: 1'b0, a: 16'd0, d: 16'h0000});
    foreach (ops[i]) begin
      push_exp(1, ops[i].wr, ops[i].a, ops[i].d);
      do_xfer(1, ops[i].wr, ops[i].a, ops[i].d, lat, rd, err, stray);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (rd !== e.rd) begin n_bad++; $display("FAIL b2b[%0d] prdata: got %h want %h", i, rd, e.rd); end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL b2b[%0d] idle outputs: %0d stray cycles, want 0", i, stray); end
    end
    go_idle(1, stray);
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL b2b pready after last: stray %0d want 0", stray); end
  endtask

  task automatic test_wait_scaling();
    op_t ops[$];
    int lat, stray;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    ops.push_back('{wr: 1'b1, a: 16'd5, d: 16'h0505});
    ops.push_back('{wr: 1'b0, a: 16'd5, d: 16'h0000});
    foreach (ops[i]) begin
      push_exp(2, ops[i].wr, ops[i].a, ops[i].d);
      do_xfer(2, ops[i].wr, ops[i].a, ops[i].d, lat, rd, err, stray);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL wait3[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (rd !== e.rd) begin n_bad++; $display("FAIL wait3[%0d] prdata: got %h want %h", i, rd, e.rd); end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL wait3[%0d] idle outputs: %0d stray cycles, want 0", i, stray); end
    end
    go_idle(2, stray);
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL wait3 pready after last: stray %0d want 0", stray); end
  endtask

  task automatic test_out_of_range();
    op_t ops[$];
    int lat, stray;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    ops.push_back('{wr: 1'b1, a: 16'd0,  d: 16'h0042});
    ops.push_back('{wr: 1'b1, a: 16'd15, d: 16'h0F0F});
    ops.push_back('{wr: 1'b1, a: 16'd16, d: 16'hFFFF});
    ops.push_back('{wr: 1'b0, a: 16'd16, d: 16'h0000});
    ops.push_back('{wr: 1'b0, a: 16'd0,  d: 16'h0000});
    ops.push_back('{wr: 1'b0, a: 16'd15, d: 16'h0000});
    foreach (ops[i]) begin
      push_exp(0, ops[i].wr, ops[i].a, ops[i].d);
      do_xfer(0, ops[i].wr, ops[i].a, ops[i].d, lat, rd, err, stray);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL oor[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (rd !== e.rd) begin n_bad++; $display("FAIL oor[%0d] prdata: got %h want %h", i, rd, e.rd); end
      n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL oor[%0d] pslverr: got %b want %b", i, err, e.err); end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL oor[%0d] idle outputs: %0d stray cycles, want 0", i, stray); end
    end
    go_idle(0, stray);
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL oor pslverr/pready after last: stray %0d want 0", stray); end
  endtask

  task automatic test_abort();
    int lat, stray, bad;
    logic [W-1:0] rd;
    logic err;
    exp_t e;
    push_exp(0, 1'b1, 16'd1, 16'h1111);
    do_xfer(0, 1'b1, 16'd1, 16'h1111, lat, rd, err, stray);
    e = sb.pop_front();
    n_cmp++;
    if (lat != e.lat || stray != 0) begin
      n_bad++;
      $display("FAIL abort_prewrite: latency %0d stray %0d, want %0d / 0", lat, stray, e.lat);
    end
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; padr[0] = 16'd1; pwd[0] = 16'hBEEF;
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (prdy[0] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL abort_pready: %0d cycles with pready=1, want 0", bad);
    end
    push_exp(0, 1'b0, 16'd1, 16'h0000);
    do_xfer(0, 1'b0, 16'd1, 16'h0000, lat, rd, err, stray);
    e = sb.pop_front();
    n_cmp++;
    if (rd !== e.rd || lat != e.lat) begin
      n_bad++;
      $display("FAIL abort_readback: prdata %h latency %0d, want %h / %0d", rd, lat, e.rd, e.lat);
    end
    go_idle(0, stray);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; padr[d] = '0; pwd[d] = '0;
      for (int a = 0; a < 16; a++) model[d][a] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_scaling();
    test_out_of_range();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
